osnt_sume_bridge_arbiter: RTL and testbench



---
 rtl/osnt_sume_arb_pkg.sv | 17 +
 rtl/osnt_sume_axis_reg_slice.sv | 68 ++++++
 rtl/osnt_sume_bridge_arbiter.sv | 165 ++++++++++++++++
 tb/tb_osnt_sume_bridge_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/osnt_sume_arb_pkg.sv
// Shared constants for the two-source packet arbiter that feeds the endianness bridge.
package osnt_sume_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StPkt0 = 2'd1;
  localparam state_t StPkt1 = 2'd2;

  localparam logic Src0 = 1'b0;
  localparam logic Src1 = 1'b1;

  function automatic logic [1:0] src_onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/osnt_sume_axis_reg_slice.sv
// One-deep AXI4-Stream output register; space_o says a beat may load this cycle.
module osnt_sume_axis_reg_slice #(
  parameter int unsigned DataWidth = 256,
  parameter int unsigned UserWidth = 128
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [DataWidth-1:0]   tdata_i,
  input  logic [DataWidth/8-1:0] tkeep_i,
  input  logic [UserWidth-1:0]   tuser_i,
  input  logic                   tlast_i,
  output logic [DataWidth-1:0]   m_tdata_o,
  output logic [DataWidth/8-1:0] m_tkeep_o,
  output logic [UserWidth-1:0]   m_tuser_o,
  output logic                   m_tlast_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic                   space_o
);

  logic [DataWidth-1:0]   tdata_q, tdata_d;
  logic [DataWidth/8-1:0] tkeep_q, tkeep_d;
  logic [UserWidth-1:0]   tuser_q, tuser_d;
  logic                   tlast_q, tlast_d;
  logic                   valid_q, valid_d;

  always_comb begin
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    valid_d = valid_q;
    if (load_i) begin
      tdata_d = tdata_i;
      tkeep_d = tkeep_i;
      tuser_d = tuser_i;
      tlast_d = tlast_i;
      valid_d = 1'b1;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tdata_q <= '0;
      tkeep_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
      valid_q <= valid_d;
    end
  end

  assign space_o    = !valid_q || m_tready_i;
  assign m_tdata_o  = tdata_q;
  assign m_tkeep_o  = tkeep_q;
  assign m_tuser_o  = tuser_q;
  assign m_tlast_o  = tlast_q;
  assign m_tvalid_o = valid_q;

endmodule

// File: rtl/osnt_sume_bridge_arbiter.sv
// Packet-granular round-robin arbiter sharing one bridge between two AXI4-Stream sources.
module osnt_sume_bridge_arbiter
  import osnt_sume_arb_pkg::*;
#(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_CNT_WIDTH        = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s0_axis_tuser,
  input  logic                           s0_axis_tlast,
  input  logic                           s0_axis_tvalid,
  output logic                           s0_axis_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]  s1_axis_tuser,
  input  logic                           s1_axis_tlast,
  input  logic                           s1_axis_tvalid,
  output logic                           s1_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic [1:0]                     cfg_en,
  output logic [C_CNT_WIDTH-1:0]         pkt_cnt0,
  output logic [C_CNT_WIDTH-1:0]         pkt_cnt1,
  output logic [1:0]                     cur_grant
);

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic [C_CNT_WIDTH-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [C_CNT_WIDTH-1:0]   pkt_cnt1_q, pkt_cnt1_d;

  logic                           space;
  logic                           sel, sel_valid;
  logic                           cand0, cand1;
  logic                           accept0, accept1, accept;
  logic [C_AXIS_DATA_WIDTH-1:0]   mux_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] mux_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  mux_tuser;
  logic                           mux_tlast;

  assign cand0 = s0_axis_tvalid && cfg_en[0];
  assign cand1 = s1_axis_tvalid && cfg_en[1];

  // Mid-packet the owner keeps the grant even while its tvalid is low or cfg_en drops.
  always_comb begin
    sel       = Src0;
    sel_valid = 1'b0;
    case (state_q)
      StPkt0: begin
        sel       = Src0;
        sel_valid = 1'b1;
      end
      StPkt1: begin
        sel       = Src1;
        sel_valid = 1'b1;
      end
      default: begin
        if (cand0 && cand1) begin
          sel       = ~last_grant_q;
          sel_valid = 1'b1;
        end else if (cand0) begin
          sel       = Src0;
          sel_valid = 1'b1;
        end else if (cand1) begin
          sel       = Src1;
          sel_valid = 1'b1;
        end
      end
    endcase
  end

  assign s0_axis_tready = !reset && sel_valid && (sel == Src0) && space;
  assign s1_axis_tready = !reset && sel_valid && (sel == Src1) && space;
  assign accept0        = s0_axis_tvalid && s0_axis_tready;
  assign accept1        = s1_axis_tvalid && s1_axis_tready;
  assign accept         = accept0 || accept1;

  always_comb begin
    if (sel == Src1) begin
      mux_tdata = s1_axis_tdata;
      mux_tkeep = s1_axis_tkeep;
      mux_tuser = s1_axis_tuser;
      mux_tlast = s1_axis_tlast;
    end else begin
      mux_tdata = s0_axis_tdata;
      mux_tkeep = s0_axis_tkeep;
      mux_tuser = s0_axis_tuser;
      mux_tlast = s0_axis_tlast;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    if (accept) begin
      if (mux_tlast) begin
        state_d      = StIdle;
        last_grant_d = sel;
      end else begin
        state_d = (sel == Src1) ? StPkt1 : StPkt0;
      end
    end
    if (accept0 && s0_axis_tlast) pkt_cnt0_d = pkt_cnt0_q + 1'b1;
    if (accept1 && s1_axis_tlast) pkt_cnt1_d = pkt_cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= Src1;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
    end
  end

  always_comb begin
    cur_grant = 2'b00;
    if (!reset) begin
      case (state_q)
        StPkt0:  cur_grant = src_onehot(Src0);
        StPkt1:  cur_grant = src_onehot(Src1);
        default: cur_grant = accept ? src_onehot(sel) : 2'b00;
      endcase
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

  osnt_sume_axis_reg_slice #(
    .DataWidth(C_AXIS_DATA_WIDTH),
    .UserWidth(C_AXIS_TUSER_WIDTH)
  ) u_out_reg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (accept),
    .tdata_i    (mux_tdata),
    .tkeep_i    (mux_tkeep),
    .tuser_i    (mux_tuser),
    .tlast_i    (mux_tlast),
    .m_tdata_o  (m_axis_tdata),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tuser_o  (m_axis_tuser),
    .m_tlast_o  (m_axis_tlast),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready),
    .space_o    (space)
  );

endmodule

// File: tb/tb_osnt_sume_bridge_arbiter.sv
// Directed bench for the bridge arbiter: grant order, gaps, backpressure, enables, wrap, reset.
module tb_osnt_sume_bridge_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0]   s0_tdata, s1_tdata, m_tdata;
  logic [DW/8-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [UW-1:0]   s0_tuser, s1_tuser, m_tuser;
  logic            s0_tlast, s1_tlast, m_tlast;
  logic            s0_tvalid, s1_tvalid, m_tvalid;
  logic            s0_tready, s1_tready, m_tready;
  logic [1:0]      cfg_en, cur_grant;
  logic [31:0]     cnt0, cnt1;

  osnt_sume_bridge_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser),
    .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser),
    .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .cfg_en(cfg_en), .pkt_cnt0(cnt0), .pkt_cnt1(cnt1), .cur_grant(cur_grant)
  );

  // Narrow-counter instance for the wrap check.
  logic [7:0] w_s0_tdata, w_m_tdata;
  logic [0:0] w_m_tkeep, w_s1_tready;
  logic [7:0] w_m_tuser;
  logic       w_s0_tvalid, w_s0_tready, w_m_tlast, w_m_tvalid;
  logic [1:0] w_cur_grant;
  logic [3:0] w_cnt0, w_cnt1;

  osnt_sume_bridge_arbiter #(
    .C_AXIS_DATA_WIDTH(8), .C_AXIS_TUSER_WIDTH(8), .C_CNT_WIDTH(4)
  ) dut_w (
    .clk(clk), .reset(reset),
    .s0_axis_tdata(w_s0_tdata), .s0_axis_tkeep(1'b1), .s0_axis_tuser(8'h00),
    .s0_axis_tlast(1'b1), .s0_axis_tvalid(w_s0_tvalid), .s0_axis_tready(w_s0_tready),
    .s1_axis_tdata(8'h00), .s1_axis_tkeep(1'b0), .s1_axis_tuser(8'h00),
    .s1_axis_tlast(1'b0), .s1_axis_tvalid(1'b0), .s1_axis_tready(w_s1_tready[0]),
    .m_axis_tdata(w_m_tdata), .m_axis_tkeep(w_m_tkeep), .m_axis_tuser(w_m_tuser),
    .m_axis_tlast(w_m_tlast), .m_axis_tvalid(w_m_tvalid), .m_axis_tready(1'b1),
    .cfg_en(2'b11), .pkt_cnt0(w_cnt0), .pkt_cnt1(w_cnt1), .cur_grant(w_cur_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [7:0] d, input logic l);
    s0_tvalid = v; s0_tdata = {248'd0, d}; s0_tlast = l;
  endtask

  task automatic drv1(input logic v, input logic [7:0] d, input logic l);
    s1_tvalid = v; s1_tdata = {248'd0, d}; s1_tlast = l;
  endtask

  initial begin
    reset = 1'b1; m_tready = 1'b1; cfg_en = 2'b11;
    s0_tkeep = '1; s1_tkeep = '1; s0_tuser = '0; s1_tuser = '0;
    drv0(0, 8'h00, 0); drv1(0, 8'h00, 0);
    w_s0_tvalid = 1'b0; w_s0_tdata = 8'h00;

    // Reset state
    cyc(); cyc();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_grant", cur_grant, 0);
    chk("rst_rdy", {s0_tready, s1_tready}, 0);
    reset = 1'b0;

    // 1: both offer 3-beat packets together; source 0 first, no gap
    drv0(1, 8'h10, 0); drv1(1, 8'h20, 0); #1;
    chk("t1_rdy_first", {s1_tready, s0_tready}, 2'b01);
    chk("t1_grant_first", cur_grant, 2'b01);
    cyc(); chk("t1_b0", m_tdata, 'h10); chk("t1_v0", m_tvalid, 1);
    drv0(1, 8'h11, 0); #1; chk("t1_s1_held", s1_tready, 0);
    cyc(); chk("t1_b1", m_tdata, 'h11);
    drv0(1, 8'h12, 1);
    cyc(); chk("t1_b2", {m_tlast, m_tdata}, {1'b1, 256'h12});
    drv0(0, 8'h00, 0); #1;
    chk("t1_s1_rdy", s1_tready, 1); chk("t1_grant_s1", cur_grant, 2'b10);
    cyc(); chk("t1_b3", {m_tvalid, m_tdata}, {1'b1, 256'h20});
    drv1(1, 8'h21, 0);
    cyc(); chk("t1_b4", m_tdata, 'h21);
    drv1(1, 8'h22, 1);
    cyc(); chk("t1_b5", {m_tlast, m_tdata}, {1'b1, 256'h22});
    chk("t1_cnt0", cnt0, 1); chk("t1_cnt1", cnt1, 1);
    drv1(0, 8'h00, 0);
    cyc(); chk("t1_idle", m_tvalid, 0);

    // 2: source 0 pauses mid-packet; source 1 stays locked out
    drv0(1, 8'hA0, 0); drv1(1, 8'hC0, 1); #1;
    chk("t2_rr_pick0", {s1_tready, s0_tready}, 2'b01);
    cyc(); chk("t2_b0", m_tdata, 'hA0);
    drv0(1, 8'hA1, 0);
    cyc(); chk("t2_b1", m_tdata, 'hA1);
    drv0(0, 8'hA2, 0); #1;
    chk("t2_gap_s1_a", s1_tready, 0); chk("t2_gap_grant", cur_grant, 2'b01);
    cyc(); chk("t2_gap_v", m_tvalid, 0); chk("t2_gap_s1_b", s1_tready, 0);
    cyc(); chk("t2_gap_v2", m_tvalid, 0);
    drv0(1, 8'hA2, 0);
    cyc(); chk("t2_b2", m_tdata, 'hA2);
    drv0(1, 8'hA3, 1); #1; chk("t2_s1_last", s1_tready, 0);
    cyc(); chk("t2_b3", {m_tlast, m_tdata}, {1'b1, 256'hA3});
    drv0(0, 8'h00, 0); #1;
    chk("t2_s1_now", s1_tready, 1);
    cyc(); chk("t2_c0", {m_tlast, m_tdata}, {1'b1, 256'hC0});
    chk("t2_cnt", {cnt0, cnt1}, {32'd2, 32'd2});
    drv1(0, 8'h00, 0);

    // 3: output backpressure for 5 cycles mid-packet
    s0_tkeep = 32'h0000_000F;
    drv0(1, 8'hD0, 0);
    cyc(); chk("t3_b0", m_tdata, 'hD0);
    drv0(1, 8'hD1, 0); s0_tkeep = 32'h0000_00FF; m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; chk("t3_rdy_low", s0_tready, 0);
      cyc();
      chk("t3_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b0, 32'h0F, 256'hD0});
    end
    m_tready = 1'b1; #1;
    chk("t3_rdy_back", s0_tready, 1);
    cyc(); chk("t3_b1", {m_tkeep, m_tdata}, {32'hFF, 256'hD1});
    drv0(1, 8'hD2, 1); s0_tuser = 128'h5A5A;
    cyc(); chk("t3_b2", {m_tlast, m_tuser, m_tdata}, {1'b1, 128'h5A5A, 256'hD2});
    chk("t3_cnt0", cnt0, 3);
    drv0(0, 8'h00, 0); s0_tkeep = '1; s0_tuser = '0;

    // 4: only source 1 enabled; disabling it mid-packet lets the packet finish
    cfg_en = 2'b10;
    drv0(1, 8'hE0, 1); drv1(1, 8'hF0, 1); #1;
    chk("t4_rdy_a", {s1_tready, s0_tready}, 2'b10);
    cyc(); chk("t4_f0", m_tdata, 'hF0);
    drv1(1, 8'hF1, 1); #1;
    chk("t4_rdy_b", {s1_tready, s0_tready}, 2'b10);
    cyc(); chk("t4_f1", m_tdata, 'hF1); chk("t4_cnt1a", cnt1, 4);
    drv1(1, 8'hF2, 0);
    cyc(); chk("t4_f2", m_tdata, 'hF2);
    cfg_en = 2'b00; drv1(1, 8'hF3, 1); #1;
    chk("t4_finish_rdy", s1_tready, 1);
    cyc(); chk("t4_f3", {m_tlast, m_tdata}, {1'b1, 256'hF3});
    chk("t4_cnt1b", cnt1, 5);
    #1; chk("t4_no_grant", {s1_tready, s0_tready, cur_grant}, 4'b0000);
    cyc(); chk("t4_idle", m_tvalid, 0); chk("t4_cnt0", cnt0, 3);
    drv0(0, 8'h00, 0); drv1(0, 8'h00, 0); cfg_en = 2'b11;

    // 6: reset while source 1 owns a packet
    drv1(1, 8'h60, 0);
    cyc(); chk("t6_in_pkt", {m_tvalid, cur_grant}, {1'b1, 2'b10});
    reset = 1'b1; drv1(1, 8'h61, 0);
    cyc();
    chk("t6_rst_v", m_tvalid, 0); chk("t6_rst_grant", cur_grant, 0);
    chk("t6_rst_cnt", {cnt0, cnt1}, 64'd0);
    reset = 1'b0;
    drv0(1, 8'h70, 1); drv1(1, 8'h71, 1); #1;
    chk("t6_first_s0", {s1_tready, s0_tready}, 2'b01);
    cyc(); chk("t6_b0", m_tdata, 'h70); chk("t6_cnt0", cnt0, 1);
    drv0(0, 8'h00, 0); drv1(0, 8'h00, 0);

    // 5: 4-bit counter wraps after 16 single-beat packets
    w_s0_tvalid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      w_s0_tdata = 8'(i);
      cyc();
    end
    chk("t5_cnt_full", w_cnt0, 4'hF);
    chk("t5_last_data", w_m_tdata, 8'h0F);
    w_s0_tdata = 8'h10;
    cyc();
    chk("t5_cnt_wrap", w_cnt0, 4'h0);
    chk("t5_cnt1", w_cnt1, 4'h0);
    w_s0_tvalid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
